// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the digit-serial add/subtract controller:
// FSM state encoding, digit size and the full-adder cell used by the slice.
package serial_add_ctrl_pkg;

    // Bits processed per cycle by the adder slice.
    localparam int DIGIT = 2;

    // Controller states; encodings are fixed so other blocks can decode them.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // One full-adder cell: returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        logic s_s;
        logic c_s;
        s_s = x ^ y ^ ci;
        c_s = (x & y) | (x & ci) | (y & ci);
        return {c_s, s_s};
    endfunction

endpackage

// File: rtl/serial_add_ctrl_slice.sv
// 2-bit ripple adder slice with carry-in, built from two full-adder cells.
// Purely combinational; the controller registers the carry between digits.
module add2_slice
    import serial_add_ctrl_pkg::*;
(
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       cin,
    output logic [1:0] s,
    output logic       cout
);

    logic [1:0] fa0_s;
    logic [1:0] fa1_s;

    // Ripple the carry from bit 0 into bit 1.
    always_comb begin
        fa0_s = full_add(a[0], b[0], cin);
        fa1_s = full_add(a[1], b[1], fa0_s[1]);
        s     = {fa1_s[0], fa0_s[0]};
        cout  = fa1_s[1];
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Digit-serial add/subtract controller. Operands are consumed two bits per
// cycle, LSB first, through a single add2_slice; the slice carry lives in a
// register between cycles. Subtraction is a + ~b + 1, so B is inverted on
// acceptance and the carry register is seeded with the sub flag.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             valid,
    input  logic             ack,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

    generate
        if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
            $error("serial_add_ctrl: WIDTH must be even and >= 2");
        end
    endgenerate

    state_e           state_r;
    state_e           state_nx_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nx_s;
    logic             carry_r;
    logic             carry_nx_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] a_sh_nx_s;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] b_sh_nx_s;
    logic [WIDTH-1:0] sum_sh_r;
    logic [WIDTH-1:0] sum_sh_nx_s;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] sum_nx_s;
    logic             cout_r;
    logic             cout_nx_s;
    logic             ready_r;
    logic             ready_nx_s;
    logic             valid_r;
    logic             valid_nx_s;
    logic             accept_s;
    logic [1:0]       slice_s;
    logic             slice_c_s;
    logic [WIDTH-1:0] shifted_s;

    add2_slice u_slice (
        .a    (a_sh_r[1:0]),
        .b    (b_sh_r[1:0]),
        .cin  (carry_r),
        .s    (slice_s),
        .cout (slice_c_s)
    );

    // Next-state, datapath and output decode for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_nx_s  = state_r;
        cnt_nx_s    = cnt_r;
        carry_nx_s  = carry_r;
        a_sh_nx_s   = a_sh_r;
        b_sh_nx_s   = b_sh_r;
        sum_sh_nx_s = sum_sh_r;
        sum_nx_s    = sum_r;
        cout_nx_s   = cout_r;
        ready_nx_s  = ready_r;
        valid_nx_s  = valid_r;
        accept_s    = 1'b0;

        // New digit enters at the top so the finished word lands LSB-aligned.
        shifted_s = sum_sh_r >> DIGIT;
        shifted_s[WIDTH-1 -: DIGIT] = slice_s;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
                end else begin
                    ready_nx_s = 1'b1;
                    valid_nx_s = 1'b0;
                end
            end
            ST_RUN: begin
                carry_nx_s  = slice_c_s;
                a_sh_nx_s   = a_sh_r >> DIGIT;
                b_sh_nx_s   = b_sh_r >> DIGIT;
                sum_sh_nx_s = shifted_s;
                if (cnt_r == LAST_CNT) begin
                    state_nx_s = ST_DONE;
                    cnt_nx_s   = '0;
                    sum_nx_s   = shifted_s;
                    cout_nx_s  = slice_c_s;
                    ready_nx_s = 1'b0;
                    valid_nx_s = 1'b1;
                end else begin
                    cnt_nx_s = cnt_r + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (ack) begin
                    valid_nx_s = 1'b0;
                    if (start) begin
                        accept_s = 1'b1;
                    end else begin
                        state_nx_s = ST_IDLE;
                        ready_nx_s = 1'b1;
                    end
                end else begin
                    valid_nx_s = 1'b1;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                ready_nx_s = 1'b1;
                valid_nx_s = 1'b0;
            end
        endcase

        // Accepting a request (from IDLE, or back-to-back from DONE with ack).
        if (accept_s) begin
            state_nx_s  = ST_RUN;
            cnt_nx_s    = '0;
            carry_nx_s  = sub;
            a_sh_nx_s   = a;
            b_sh_nx_s   = b ^ {WIDTH{sub}};
            sum_sh_nx_s = '0;
            ready_nx_s  = 1'b0;
            valid_nx_s  = 1'b0;
        end else begin
            accept_s = 1'b0;
        end
    end

    // State, datapath and output registers; async reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            carry_r  <= 1'b0;
            a_sh_r   <= '0;
            b_sh_r   <= '0;
            sum_sh_r <= '0;
            sum_r    <= '0;
            cout_r   <= 1'b0;
            ready_r  <= 1'b1;
            valid_r  <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            cnt_r    <= cnt_nx_s;
            carry_r  <= carry_nx_s;
            a_sh_r   <= a_sh_nx_s;
            b_sh_r   <= b_sh_nx_s;
            sum_sh_r <= sum_sh_nx_s;
            sum_r    <= sum_nx_s;
            cout_r   <= cout_nx_s;
            ready_r  <= ready_nx_s;
            valid_r  <= valid_nx_s;
        end
    end

    assign ready = ready_r;
    assign valid = valid_r;
    assign sum   = sum_r;
    assign cout  = cout_r;

endmodule
